// File: rtl/mac_accumulator.sv
// Sums VECTOR_LEN consecutive products into one saturating dot product per vector.
// Latency: o_valid rises on the edge after the last product beat of a vector.
// Backpressure: none on the input; a result completing while the output register is held is dropped and flagged.
module mac_accumulator #(
    parameter int DATAWIDTH  = 4,
    parameter int VECTOR_LEN = 4,
    parameter int ACC_WIDTH  = 2*DATAWIDTH + $clog2(VECTOR_LEN)
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            i_valid,
    input  logic [2*DATAWIDTH-1:0]          i_z,
    input  logic                            i_clear,
    output logic                            o_valid,
    input  logic                            i_ready,
    output logic [ACC_WIDTH-1:0]            o_result,
    output logic                            o_sat,
    output logic [$clog2(VECTOR_LEN+1)-1:0] o_count,
    output logic                            o_drop
);

    localparam int CW = $clog2(VECTOR_LEN+1);
    localparam logic [ACC_WIDTH-1:0] ACC_MAX  = '1;
    localparam logic [CW-1:0]        LAST_CNT = CW'(VECTOR_LEN-1);

    logic [ACC_WIDTH-1:0] acc_q;
    logic [CW-1:0]        cnt_q;
    logic                 sat_q;

    logic [ACC_WIDTH-1:0] acc_base;
    logic [CW-1:0]        cnt_base;
    logic                 sat_base;
    logic [ACC_WIDTH:0]   sum;
    logic                 sat_next;
    logic [ACC_WIDTH-1:0] acc_next;
    logic                 complete;
    logic                 out_free;

    // A clear in the same cycle as a beat makes that beat the first of a fresh vector.
    always_comb begin
        acc_base = i_clear ? '0 : acc_q;
        cnt_base = i_clear ? '0 : cnt_q;
        sat_base = i_clear ? 1'b0 : sat_q;
        sum      = {1'b0, acc_base} + (ACC_WIDTH+1)'(i_z);
        sat_next = sat_base | sum[ACC_WIDTH];
        acc_next = sat_next ? ACC_MAX : sum[ACC_WIDTH-1:0];
        complete = i_valid && (cnt_base == LAST_CNT);
        out_free = !o_valid || i_ready;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_q <= '0;
            cnt_q <= '0;
            sat_q <= 1'b0;
        end else if (complete) begin
            acc_q <= '0;
            cnt_q <= '0;
            sat_q <= 1'b0;
        end else if (i_valid) begin
            acc_q <= acc_next;
            cnt_q <= cnt_base + CW'(1);
            sat_q <= sat_next;
        end else if (i_clear) begin
            acc_q <= '0;
            cnt_q <= '0;
            sat_q <= 1'b0;
        end
    end

    // Accept and load in the same cycle keep o_valid high with the new result.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            o_valid  <= 1'b0;
            o_result <= '0;
            o_sat    <= 1'b0;
            o_drop   <= 1'b0;
        end else begin
            if (complete && out_free) begin
                o_valid  <= 1'b1;
                o_result <= acc_next;
                o_sat    <= sat_next;
            end else if (o_valid && i_ready) begin
                o_valid  <= 1'b0;
            end

            if (complete && !out_free) begin
                o_drop <= 1'b1;
            end else if (i_clear) begin
                o_drop <= 1'b0;
            end
        end
    end

    assign o_count = cnt_q;

endmodule

// File: tb/tb_mac_accumulator.sv
// Bench for mac_accumulator: two instances (default width and a 9-bit accumulator) share one stimulus.
module tb_mac_accumulator;

    localparam int VL = 4;
    localparam longint MAX0 = (64'd1 << 10) - 1;
    localparam longint MAX1 = (64'd1 << 9) - 1;

    logic       clk = 1'b0;
    logic       rst;
    logic       i_valid;
    logic [7:0] i_z;
    logic       i_clear;
    logic       i_ready;

    logic       o_valid0, o_sat0, o_drop0;
    logic [9:0] o_result0;
    logic [2:0] o_count0;
    logic       o_valid1, o_sat1, o_drop1;
    logic [8:0] o_result1;
    logic [2:0] o_count1;

    int checks = 0;
    int errors = 0;

    mac_accumulator dut0 (
        .clk(clk), .rst(rst), .i_valid(i_valid), .i_z(i_z), .i_clear(i_clear),
        .o_valid(o_valid0), .i_ready(i_ready), .o_result(o_result0), .o_sat(o_sat0),
        .o_count(o_count0), .o_drop(o_drop0)
    );

    mac_accumulator #(.ACC_WIDTH(9)) dut1 (
        .clk(clk), .rst(rst), .i_valid(i_valid), .i_z(i_z), .i_clear(i_clear),
        .o_valid(o_valid1), .i_ready(i_ready), .o_result(o_result1), .o_sat(o_sat1),
        .o_count(o_count1), .o_drop(o_drop1)
    );

    always #5 clk = ~clk;

    // Reference: a vector's result is min(total, max) and it saturated iff total > max.
    longint m_sum  = 0;
    int     m_cnt  = 0;
    bit     m_vld  = 0;
    bit     m_drop = 0;
    longint m_res0 = 0, m_res1 = 0;
    bit     m_sat0 = 0, m_sat1 = 0;
    bit     m_done, m_free;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_sum = 0; m_cnt = 0; m_vld = 0; m_drop = 0;
            m_res0 = 0; m_res1 = 0; m_sat0 = 0; m_sat1 = 0;
        end else begin
            m_done = 0;
            m_free = !m_vld || i_ready;
            if (i_clear) begin
                m_sum = 0;
                m_cnt = 0;
                m_drop = 0;
            end
            if (i_valid) begin
                m_sum = m_sum + longint'(i_z);
                m_cnt = m_cnt + 1;
                if (m_cnt == VL) m_done = 1;
            end
            if (m_done) begin
                if (m_free) begin
                    m_vld  = 1;
                    m_res0 = (m_sum > MAX0) ? MAX0 : m_sum;
                    m_sat0 = (m_sum > MAX0);
                    m_res1 = (m_sum > MAX1) ? MAX1 : m_sum;
                    m_sat1 = (m_sum > MAX1);
                end else begin
                    m_drop = 1;
                end
                m_sum = 0;
                m_cnt = 0;
            end else if (m_vld && i_ready) begin
                m_vld = 0;
            end
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("valid0",  64'(o_valid0),  64'(m_vld));
        chk("valid1",  64'(o_valid1),  64'(m_vld));
        chk("count0",  64'(o_count0),  64'(m_cnt));
        chk("count1",  64'(o_count1),  64'(m_cnt));
        chk("drop0",   64'(o_drop0),   64'(m_drop));
        chk("drop1",   64'(o_drop1),   64'(m_drop));
        chk("result0", 64'(o_result0), 64'(m_res0));
        chk("result1", 64'(o_result1), 64'(m_res1));
        chk("sat0",    64'(o_sat0),    64'(m_sat0));
        chk("sat1",    64'(o_sat1),    64'(m_sat1));
    end

    task automatic cyc(input bit v, input int z, input bit clr, input bit rdy);
        i_valid = v;
        i_z     = 8'(z);
        i_clear = clr;
        i_ready = rdy;
        @(posedge clk);
        #1;
        i_valid = 1'b0;
        i_clear = 1'b0;
    endtask

    task automatic vec4(input int a, input int b, input int c, input int d, input bit rdy);
        cyc(1, a, 0, rdy);
        cyc(1, b, 0, rdy);
        cyc(1, c, 0, rdy);
        cyc(1, d, 0, rdy);
    endtask

    initial begin
        rst = 1'b1; i_valid = 1'b0; i_z = '0; i_clear = 1'b0; i_ready = 1'b0;
        #1 rst = 1'b0;
        #2;
        chk("rst_valid",  64'(o_valid0),  64'd0);
        chk("rst_result", 64'(o_result0), 64'd0);
        chk("rst_count",  64'(o_count0),  64'd0);
        chk("rst_drop",   64'(o_drop0),   64'd0);
        @(negedge clk); #1 rst = 1'b1;
        @(posedge clk); #1;

        // Basic vector 3+5+7+9
        cyc(1, 3, 0, 1); cyc(1, 5, 0, 1); cyc(1, 7, 0, 1);
        chk("t1_pre_valid", 64'(o_valid0), 64'd0);
        chk("t1_pre_count", 64'(o_count0), 64'd3);
        cyc(1, 9, 0, 1);
        chk("t1_valid",  64'(o_valid0),  64'd1);
        chk("t1_result", 64'(o_result0), 64'd24);
        chk("t1_sat",    64'(o_sat0),    64'd0);
        chk("t1_count",  64'(o_count0),  64'd0);
        cyc(0, 0, 0, 1);

        // Saturation in the narrow instance only
        vec4(225, 225, 225, 225, 1);
        chk("t2_result0", 64'(o_result0), 64'd900);
        chk("t2_sat0",    64'(o_sat0),    64'd0);
        chk("t2_result1", 64'(o_result1), 64'd511);
        chk("t2_sat1",    64'(o_sat1),    64'd1);
        vec4(1, 1, 1, 1, 1);
        chk("t2_next1", 64'(o_result1), 64'd4);
        chk("t2_nsat1", 64'(o_sat1),    64'd0);
        cyc(0, 0, 0, 1);

        // Drop while output register is held
        vec4(1, 2, 3, 4, 0);
        vec4(2, 4, 6, 8, 0);
        chk("t3_held",  64'(o_result0), 64'd10);
        chk("t3_drop",  64'(o_drop0),   64'd1);
        chk("t3_valid", 64'(o_valid0),  64'd1);
        cyc(0, 0, 0, 1);
        chk("t3_accepted", 64'(o_valid0),  64'd0);
        chk("t3_hold_res", 64'(o_result0), 64'd10);
        cyc(0, 0, 1, 0);
        chk("t3_clr_drop", 64'(o_drop0), 64'd0);

        // Accept coincides with the next completion
        vec4(1, 1, 1, 1, 0);
        cyc(1, 2, 0, 0); cyc(1, 2, 0, 0); cyc(1, 2, 0, 0);
        chk("t4_pending", 64'(o_result0), 64'd4);
        cyc(1, 2, 0, 1);
        chk("t4_valid",  64'(o_valid0),  64'd1);
        chk("t4_result", 64'(o_result0), 64'd8);
        chk("t4_drop",   64'(o_drop0),   64'd0);
        cyc(0, 0, 0, 1);

        // Clear with a beat restarts the vector
        cyc(1, 5, 0, 1); cyc(1, 5, 0, 1);
        cyc(1, 7, 1, 1);
        chk("t5_count", 64'(o_count0), 64'd1);
        cyc(1, 1, 0, 1); cyc(1, 1, 0, 1);
        chk("t5_novalid", 64'(o_valid0), 64'd0);
        cyc(1, 1, 0, 1);
        chk("t5_result", 64'(o_result0), 64'd10);
        cyc(0, 0, 0, 1);

        // Asynchronous reset mid-vector with a pending result
        vec4(1, 1, 1, 1, 0);
        cyc(1, 2, 0, 0); cyc(1, 2, 0, 0);
        chk("t6_pre_count", 64'(o_count0), 64'd2);
        chk("t6_pre_valid", 64'(o_valid0), 64'd1);
        #2 rst = 1'b0;
        #1;
        chk("t6_valid",  64'(o_valid0),  64'd0);
        chk("t6_result", 64'(o_result0), 64'd0);
        chk("t6_count",  64'(o_count0),  64'd0);
        chk("t6_sat1",   64'(o_sat1),    64'd0);
        @(negedge clk); #1 rst = 1'b1;
        @(posedge clk); #1;
        vec4(2, 2, 2, 2, 1);
        chk("t6_result_after", 64'(o_result0), 64'd8);

        // Randomized traffic against the reference
        for (int n = 0; n < 600; n++) begin
            int z;
            z = ($urandom_range(0, 7) == 0) ? 225 : $urandom_range(0, 15) * $urandom_range(0, 15);
            cyc($urandom_range(0, 9) < 7, z, $urandom_range(0, 24) == 0, $urandom_range(0, 2) != 0);
        end
        cyc(0, 0, 0, 1);
        @(negedge clk);
        #1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
